// File: rtl/median3x3_pipe.sv
// ---------------------------------------------------------------------------
// median3x3_pipe
//
// Three-stage pipelined 3x3 rank filter. Each accepted window of nine pixels
// produces one output pixel. The output is the median, minimum or maximum of
// the nine pixels, or the raw centre pixel. Every channel is ranked on its own.
//
// The median uses the row-sort decomposition:
//   S1 sorts each row into (hi, md, lo).
//   S2 reduces across the rows:
//        a    = min of the row hi values
//        b    = median of the row md values
//        c    = max of the row lo values
//        gmin = min of the row lo values
//        gmax = max of the row hi values
//   S3 takes med3(a, b, c), which is the median of all nine values.
//      It can instead take gmin, gmax or the centre pixel, as the mode selects.
//
// Flow control:
//   - A stall (out_valid & ~out_ready) freezes the whole pipeline.
//   - in_ready is the inverse of stall.
//   - Bubbles advance like data, so they are not squeezed out.
//
// Parameters
//   CW : bits per channel (unsigned compare)
//   CH : channels per pixel; pixel width PW = CH*CW
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous reset, active high; flushes all stages
//   in_valid  : in_win / in_mode carry a window
//   in_ready  : block can accept a window this cycle
//   in_win    : 9 pixels, pixel k at [k*PW +: PW], rows of three (k=0..8)
//   in_mode   : 0 median, 1 min, 2 max, 3 centre pixel (k=4)
//   out_valid : out_pix holds a result
//   out_ready : downstream accepts out_pix
//   out_pix   : result pixel, channel c at [c*CW +: CW]
// ---------------------------------------------------------------------------
module median3x3_pipe #(
  parameter int CW = 8,
  parameter int CH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [9*CH*CW-1:0]   in_win,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*CW-1:0]     out_pix
);

  localparam int PW = CH * CW;

  typedef logic [CW-1:0]          chan_t;
  typedef logic [CH-1:0][CW-1:0]  pix_t;   // one pixel, channel-indexed
  typedef logic [2:0][CH-1:0][CW-1:0] rows_t; // one value per row per channel

  typedef enum logic [1:0] {
    MODE_MED = 2'd0,
    MODE_MIN = 2'd1,
    MODE_MAX = 2'd2,
    MODE_CTR = 2'd3
  } mode_e;

  // -------------------------------------------------------------------------
  // Compare primitives.
  // Every result is one of the inputs, so nothing grows in width.
  // Ties may pick either operand; equal values give the same output.
  // -------------------------------------------------------------------------
  function automatic chan_t max2(input chan_t x, input chan_t y);
    return (x >= y) ? x : y;
  endfunction

  function automatic chan_t min2(input chan_t x, input chan_t y);
    return (x >= y) ? y : x;
  endfunction

  function automatic chan_t max3(input chan_t x, input chan_t y, input chan_t z);
    return max2(max2(x, y), z);
  endfunction

  function automatic chan_t min3(input chan_t x, input chan_t y, input chan_t z);
    return min2(min2(x, y), z);
  endfunction

  // Median of three: the larger of min(x,y) and min(max(x,y), z).
  function automatic chan_t med3(input chan_t x, input chan_t y, input chan_t z);
    return max2(min2(x, y), min2(max2(x, y), z));
  endfunction

  // Channel c of pixel k in the flat window bus.
  function automatic chan_t win_chan(input logic [9*PW-1:0] w, input int k, input int c);
    return w[k*PW + c*CW +: CW];
  endfunction

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  logic stall;
  logic advance;

  logic out_valid_q, out_valid_d;
  pix_t out_pix_q,   out_pix_d;

  assign stall     = out_valid_q & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;

  // -------------------------------------------------------------------------
  // Stage 1: sort each row of the incoming window.
  // -------------------------------------------------------------------------
  logic  s1_valid_q, s1_valid_d;
  rows_t s1_hi_q,    s1_hi_d;
  rows_t s1_md_q,    s1_md_d;
  rows_t s1_lo_q,    s1_lo_d;
  pix_t  s1_ctr_q,   s1_ctr_d;
  mode_e s1_mode_q,  s1_mode_d;

  always_comb begin
    // NOTE: every combinational output gets a default first. That way no path
    // leaves a signal unassigned, and no latch can be inferred.
    s1_valid_d = s1_valid_q;
    s1_hi_d    = s1_hi_q;
    s1_md_d    = s1_md_q;
    s1_lo_d    = s1_lo_q;
    s1_ctr_d   = s1_ctr_q;
    s1_mode_d  = s1_mode_q;
    if (advance) begin
      // An empty slot still loads; in_valid=0 marks it as a bubble.
      s1_valid_d = in_valid;
      s1_mode_d  = mode_e'(in_mode);
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < CH; c++) begin
          s1_hi_d[r][c] = max3(win_chan(in_win, 3*r,   c),
                               win_chan(in_win, 3*r+1, c),
                               win_chan(in_win, 3*r+2, c));
          s1_md_d[r][c] = med3(win_chan(in_win, 3*r,   c),
                               win_chan(in_win, 3*r+1, c),
                               win_chan(in_win, 3*r+2, c));
          s1_lo_d[r][c] = min3(win_chan(in_win, 3*r,   c),
                               win_chan(in_win, 3*r+1, c),
                               win_chan(in_win, 3*r+2, c));
        end
      end
      for (int c = 0; c < CH; c++) begin
        s1_ctr_d[c] = win_chan(in_win, 4, c);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: reduce across the rows.
  // -------------------------------------------------------------------------
  logic  s2_valid_q, s2_valid_d;
  pix_t  s2_a_q,     s2_a_d;
  pix_t  s2_b_q,     s2_b_d;
  pix_t  s2_c_q,     s2_c_d;
  pix_t  s2_gmin_q,  s2_gmin_d;
  pix_t  s2_gmax_q,  s2_gmax_d;
  pix_t  s2_ctr_q,   s2_ctr_d;
  mode_e s2_mode_q,  s2_mode_d;

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_a_d     = s2_a_q;
    s2_b_d     = s2_b_q;
    s2_c_d     = s2_c_q;
    s2_gmin_d  = s2_gmin_q;
    s2_gmax_d  = s2_gmax_q;
    s2_ctr_d   = s2_ctr_q;
    s2_mode_d  = s2_mode_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_mode_d  = s1_mode_q;
      s2_ctr_d   = s1_ctr_q;
      for (int c = 0; c < CH; c++) begin
        s2_a_d[c]    = min3(s1_hi_q[0][c], s1_hi_q[1][c], s1_hi_q[2][c]);
        s2_b_d[c]    = med3(s1_md_q[0][c], s1_md_q[1][c], s1_md_q[2][c]);
        s2_c_d[c]    = max3(s1_lo_q[0][c], s1_lo_q[1][c], s1_lo_q[2][c]);
        s2_gmin_d[c] = min3(s1_lo_q[0][c], s1_lo_q[1][c], s1_lo_q[2][c]);
        s2_gmax_d[c] = max3(s1_hi_q[0][c], s1_hi_q[1][c], s1_hi_q[2][c]);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: select the result by mode into the output register.
  // While stalled it holds, so out_pix stays stable for downstream.
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    if (advance) begin
      out_valid_d = s2_valid_q;
      for (int c = 0; c < CH; c++) begin
        case (s2_mode_q)
          MODE_MED: out_pix_d[c] = med3(s2_a_q[c], s2_b_q[c], s2_c_q[c]);
          MODE_MIN: out_pix_d[c] = s2_gmin_q[c];
          MODE_MAX: out_pix_d[c] = s2_gmax_q[c];
          MODE_CTR: out_pix_d[c] = s2_ctr_q[c];
          default:  out_pix_d[c] = s2_ctr_q[c];
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the data registers are cleared along with the valids, not only the
    // valids. This way out_pix reads 0 after reset and no stale pixel is visible.
    if (rst) begin
      // NOTE: state registers use non-blocking assignments. Every flop then
      // samples its pre-edge value, whatever order the statements are in.
      s1_valid_q  <= 1'b0;
      s1_hi_q     <= '0;
      s1_md_q     <= '0;
      s1_lo_q     <= '0;
      s1_ctr_q    <= '0;
      s1_mode_q   <= MODE_MED;
      s2_valid_q  <= 1'b0;
      s2_a_q      <= '0;
      s2_b_q      <= '0;
      s2_c_q      <= '0;
      s2_gmin_q   <= '0;
      s2_gmax_q   <= '0;
      s2_ctr_q    <= '0;
      s2_mode_q   <= MODE_MED;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hi_q     <= s1_hi_d;
      s1_md_q     <= s1_md_d;
      s1_lo_q     <= s1_lo_d;
      s1_ctr_q    <= s1_ctr_d;
      s1_mode_q   <= s1_mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_a_q      <= s2_a_d;
      s2_b_q      <= s2_b_d;
      s2_c_q      <= s2_c_d;
      s2_gmin_q   <= s2_gmin_d;
      s2_gmax_q   <= s2_gmax_d;
      s2_ctr_q    <= s2_ctr_d;
      s2_mode_q   <= s2_mode_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
    end
  end

endmodule

// File: tb/tb_median3x3_pipe.sv
// ---------------------------------------------------------------------------
// tb_median3x3_pipe
//
// Directed and randomized stimulus for median3x3_pipe (CW=8, CH=3).
//
// The reference model keeps a queue of expected pixels, one per accepted
// window. Each entry comes from a plain sort of the nine values of each
// channel:
//   - median is element 4 of the sorted list,
//   - minimum is element 0,
//   - maximum is element 8,
//   - the centre pixel is k=4.
// Every output handshake is compared against the head of the queue.
// ---------------------------------------------------------------------------
module tb_median3x3_pipe;

  localparam int CW = 8;
  localparam int CH = 3;
  localparam int PW = CW * CH;

  typedef int vals_t [9];

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [9*PW-1:0]   in_win;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [PW-1:0]     out_pix;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  bit acc;

  logic [PW-1:0] exp_q [$];

  median3x3_pipe #(.CW(CW), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_win    (in_win),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: per channel, sort the nine values and pick by rank.
  function automatic logic [PW-1:0] model(input logic [9*PW-1:0] w, input logic [1:0] m);
    logic [PW-1:0] r;
    int v [9];
    int s [9];
    int t;
    int sel;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 9; k++) v[k] = int'(w[k*PW + c*CW +: CW]);
      s = v;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8 - i; j++)
          if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
      case (m)
        2'd0:    sel = s[4];
        2'd1:    sel = s[0];
        2'd2:    sel = s[8];
        default: sel = v[4];
      endcase
      r[c*CW +: CW] = sel[CW-1:0];
    end
    return r;
  endfunction

  task automatic set_win(input vals_t v0, input vals_t v1, input vals_t v2);
    for (int k = 0; k < 9; k++) begin
      in_win[k*PW + 0*CW +: CW] = v0[k][CW-1:0];
      in_win[k*PW + 1*CW +: CW] = v1[k][CW-1:0];
      in_win[k*PW + 2*CW +: CW] = v2[k][CW-1:0];
    end
  endtask

  task automatic set_uni(input vals_t v);
    set_win(v, v, v);
  endtask

  task automatic rand_win();
    for (int k = 0; k < 9; k++)
      for (int c = 0; c < CH; c++)
        in_win[k*PW + c*CW +: CW] = CW'($urandom);
  endtask

  // One clock cycle.
  // Before the edge, the output handshake is scored and an accept is recorded
  // in the model.
  // After the edge, a cycle that was stalled must show its output held.
  task automatic tick();
    bit            was_stall;
    logic [PW-1:0] held;
    #2;
    acc       = 1'b0;
    was_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
    held      = out_pix;
    if (!rst) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        else begin
          check("out_pix_vs_model", {40'd0, out_pix}, {40'd0, exp_q.pop_front()});
          n_out++;
        end
      end
      if (was_stall) check("in_ready_during_stall", {63'd0, in_ready}, 64'd0);
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back(model(in_win, in_mode));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rst) exp_q.delete();
    else if (was_stall) begin
      check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
      check("stall_hold_pix", {40'd0, out_pix}, {40'd0, held});
    end
  endtask

  // Send one window into an empty, unstalled pipe and check it at E+2.
  task automatic send_one(input string tag, input logic [1:0] m, input logic [PW-1:0] expv);
    in_mode  = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check(tag, {40'd0, out_pix}, {40'd0, expv});
    tick();
  endtask

  vals_t w_med  = '{9, 1, 5, 3, 7, 2, 8, 4, 6};
  vals_t w_up   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  vals_t w_dn   = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
  vals_t w_80   = '{8'h80, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80};
  vals_t w_ff   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  vals_t w_lo4  = '{0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  vals_t w_lo5  = '{0, 0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  vals_t w_3c   = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};

  initial begin
    logic [9*PW-1:0] bp_win  [6];
    logic [1:0]      bp_mode [6];
    int sent;
    int base;
    int stall_left;

    // ---- Reset with in_valid high and random data ----
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_mode   = 2'($urandom);
    rand_win();
    tick();
    rand_win();
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_pix", {40'd0, out_pix}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // ---- Median and latency from reset release ----
    rst      = 1'b0;
    set_uni(w_med);
    in_mode  = 2'd0;
    in_valid = 1'b1;
    tick();                                   // edge E: accept
    in_valid = 1'b0;
    check("lat_after_E", {63'd0, out_valid}, 64'd0);
    tick();                                   // E+1
    check("lat_after_E1", {63'd0, out_valid}, 64'd0);
    tick();                                   // E+2
    check("lat_after_E2", {63'd0, out_valid}, 64'd1);
    check("median_basic", {40'd0, out_pix}, 64'h050505);
    tick();
    check("valid_one_cycle", {63'd0, out_valid}, 64'd0);

    // ---- Channel independence ----
    set_win(w_up, w_dn, w_80);
    send_one("chan_indep", 2'd0, 24'h800505);

    // ---- Modes back-to-back: 1, 2, 3, 0 ----
    set_uni(w_med);
    in_valid = 1'b1;
    in_mode  = 2'd1; tick();
    in_mode  = 2'd2; tick();
    in_mode  = 2'd3; tick();
    check("mode_min", {40'd0, out_pix}, 64'h010101);
    in_mode  = 2'd0; tick();
    check("mode_max", {40'd0, out_pix}, 64'h090909);
    in_valid = 1'b0;
    tick();
    check("mode_ctr", {40'd0, out_pix}, 64'h070707);
    tick();
    check("mode_med", {40'd0, out_pix}, 64'h050505);
    check("mode_med_valid", {63'd0, out_valid}, 64'd1);
    tick();

    // ---- Backpressure: 6 windows, 4-cycle stall once output is valid ----
    for (int i = 0; i < 6; i++) begin
      rand_win();
      in_win[0 +: CW] = CW'(i);             // keeps the windows distinct
      bp_win[i]  = in_win;
      bp_mode[i] = 2'($urandom);
    end
    sent       = 0;
    base       = n_out;
    stall_left = 4;
    for (int cyc = 0; cyc < 80 && (n_out - base) < 6; cyc++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_win  = bp_win[sent];
        in_mode = bp_mode[sent];
      end
      if (out_valid === 1'b1 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      tick();
      if (acc) sent++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("bp_results_count", 64'(n_out - base), 64'd6);
    check("bp_stall_applied", 64'(stall_left), 64'd0);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // ---- Reset mid-stream flushes everything ----
    for (int i = 0; i < 3; i++) begin
      rand_win();
      in_mode  = 2'($urandom);
      in_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_out_pix", {40'd0, out_pix}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_no_partial", {63'd0, out_valid}, 64'd0);
    end

    // ---- Extremes ----
    set_uni(w_ff);  send_one("ext_all_ff", 2'd0, 24'hFFFFFF);
    set_uni(w_lo4); send_one("ext_lo4_ff", 2'd0, 24'hFFFFFF);
    set_uni(w_lo5); send_one("ext_lo5_00", 2'd0, 24'h000000);
    set_uni(w_3c);  send_one("ext_all_3c", 2'd0, 24'h3C3C3C);

    // ---- Randomized traffic with random backpressure ----
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_mode   = 2'($urandom);
      rand_win();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) tick();
    check("rand_drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
    check("rand_idle_valid", {63'd0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
